// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the byte-addressed instruction memory.
//
// A framed byte stream arrives over valid/ready. The frame is LEN_HI, LEN_LO
// (16-bit big-endian word count N), then 4*N payload bytes, then CHK, the
// payload sum mod 256. Each payload byte is written to BASE_ADDR + k, so the
// most significant byte of each word lands at the lowest address. The core is
// held in reset until a frame has loaded and its checksum has matched.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader can accept a byte (decoded from the state register)
//   reload    restart frame reception from DONE or ERROR
//   wr_en     imem byte write strobe (registered)
//   wr_addr   imem byte address (registered)
//   wr_data   imem byte data (registered)
//   core_rst  processor core reset, released only in DONE (registered)
//   done      frame loaded and verified (registered)
//   err       frame rejected (registered)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          MEM_BYTES = 4096,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // Running checksum: plain 8-bit wrapping sum.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [7:0]          len_hi_r, len_hi_nxt_s;
  logic [17:0]         count_r, count_nxt_s;
  logic [17:0]         total_r, total_nxt_s;
  logic [7:0]          chk_r, chk_nxt_s;
  logic                wr_en_r, wr_en_nxt_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_nxt_s;
  logic [7:0]          wr_data_r, wr_data_nxt_s;
  logic                core_rst_r, done_r, err_r;
  logic                accept_s;
  logic [15:0]         len_s;
  logic [33:0]         end_addr_s;
  logic                len_bad_s;

  assign in_ready = (state_r != ST_DONE) && (state_r != ST_ERROR);
  assign accept_s = in_valid && in_ready;

  // Length check is done in 34 bits so BASE_ADDR + 4*N can never wrap.
  assign len_s      = {len_hi_r, in_data};
  assign end_addr_s = 34'(BASE_ADDR) + {16'd0, len_s, 2'b00};
  assign len_bad_s  = (len_s == 16'd0) || (end_addr_s > 34'(MEM_BYTES));

  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign core_rst = core_rst_r;
  assign done     = done_r;
  assign err      = err_r;

  // Next-state and next-datapath logic for the frame receiver.
  always_comb begin
    state_nxt_s   = state_r;
    len_hi_nxt_s  = len_hi_r;
    count_nxt_s   = count_r;
    total_nxt_s   = total_r;
    chk_nxt_s     = chk_r;
    wr_en_nxt_s   = 1'b0;
    wr_addr_nxt_s = wr_addr_r;
    wr_data_nxt_s = wr_data_r;
    case (state_r)
      ST_LEN_HI: begin
        if (accept_s) begin
          len_hi_nxt_s = in_data;
          state_nxt_s  = ST_LEN_LO;
        end else begin
          state_nxt_s  = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          count_nxt_s = 18'd0;
          chk_nxt_s   = 8'd0;
          total_nxt_s = {len_s, 2'b00};
          if (len_bad_s) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else begin
          state_nxt_s = ST_LEN_LO;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = ADDR_W'(BASE_ADDR + 32'(count_r));
          wr_data_nxt_s = in_data;
          chk_nxt_s     = chk_add(chk_r, in_data);
          count_nxt_s   = count_r + 18'd1;
          if (count_r == total_r - 18'd1) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (in_data == chk_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ERROR;
          end
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_nxt_s = ST_LEN_HI;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_LEN_HI;
      end
    endcase
  end

  // State, datapath and output registers; status outputs follow the next state
  // so done/core_rst change on the very edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_LEN_HI;
      len_hi_r   <= 8'd0;
      count_r    <= 18'd0;
      total_r    <= 18'd0;
      chk_r      <= 8'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= ADDR_W'(BASE_ADDR);
      wr_data_r  <= 8'd0;
      core_rst_r <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      len_hi_r   <= len_hi_nxt_s;
      count_r    <= count_nxt_s;
      total_r    <= total_nxt_s;
      chk_r      <= chk_nxt_s;
      wr_en_r    <= wr_en_nxt_s;
      wr_addr_r  <= wr_addr_nxt_s;
      wr_data_r  <= wr_data_nxt_s;
      core_rst_r <= (state_nxt_s != ST_DONE);
      done_r     <= (state_nxt_s == ST_DONE);
      err_r      <= (state_nxt_s == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames,
// with expected writes and outcomes derived from the frame format rules.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_rst;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] last_addr = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the next expected byte write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check_eq("spurious_wr", {24'd0, wr_data}, 32'hFFFF_FFFF);
      end else begin
        check_eq("wr_addr", wr_addr, exp_addr_q.pop_front());
        check_eq("wr_data", {24'd0, wr_data}, {24'd0, exp_data_q.pop_front()});
      end
      last_addr = wr_addr;
    end
  end

  function automatic int frame_len();
    return int'({frame_q[0], frame_q[1]});
  endfunction

  function automatic bit len_ok(input int n);
    return (n != 0) && (256 + 4 * n <= 4096);
  endfunction

  // Frame accepted iff the length fits and CHK equals the payload sum mod 256.
  function automatic bit model_ok();
    int n;
    int sum;
    n = frame_len();
    if (!len_ok(n)) return 1'b0;
    sum = 0;
    for (int i = 0; i < 4 * n; i++) sum += int'(frame_q[2 + i]);
    return (sum % 256) == int'(frame_q[2 + 4 * n]);
  endfunction

  task automatic build(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] s;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    s = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      s = s + b;
    end
    frame_q.push_back(bad ? s + 8'd1 : s);
  endtask

  task automatic load_fixed();
    frame_q = '{8'h00, 8'h02, 8'h00, 8'h90, 8'h04, 8'h93,
                8'h00, 8'h50, 8'h02, 8'h93, 8'h0C};
  endtask

  // Send the first nb bytes of frame_q; payload bytes are logged as expected writes.
  task automatic send(input int nb, input bit gaps, input bit rl);
    int  n;
    bit  lok;
    bit  acc;
    bit  stop;
    int  budget;
    n    = frame_len();
    lok  = len_ok(n);
    stop = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (lok && i >= 2 && i < 2 + 4 * n) begin
        exp_addr_q.push_back(32'h100 + 32'(i - 2));
        exp_data_q.push_back(frame_q[i]);
      end
      in_data = frame_q[i];
      reload  = rl && (i != frame_q.size() - 1);
      acc     = 1'b0;
      budget  = 0;
      while (!acc && !stop) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        budget++;
        if (!acc && budget > 40) begin
          check_eq("accept_timeout", {31'd0, in_ready}, 32'd1);
          stop = 1'b1;
        end
      end
      if (stop) break;
    end
    in_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic check_outcome(input bit ok);
    check_eq("done", {31'd0, done}, {31'd0, ok});
    check_eq("err", {31'd0, err}, {31'd0, !ok});
    check_eq("core_rst", {31'd0, core_rst}, {31'd0, !ok});
    check_eq("ready_end", {31'd0, in_ready}, 32'd0);
    check_eq("wr_missing", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_reset();
    check_eq("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_eq("rst_wr_addr", wr_addr, 32'h100);
    check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_eq("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check_eq("rl_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rl_err", {31'd0, err}, 32'd0);
    check_eq("rl_done", {31'd0, done}, 32'd0);
    check_eq("rl_core_rst", {31'd0, core_rst}, 32'd1);
  endtask

  initial begin
    bit ok;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    // Reference frame, continuous and with gaps.
    load_fixed();
    send(frame_q.size(), 1'b0, 1'b0);
    check_outcome(1'b1);
    do_reload();
    send(frame_q.size(), 1'b1, 1'b0);
    check_outcome(1'b1);
    do_reload();

    // Bad checksum: writes still happen, then error, then recovery.
    frame_q[10] = 8'h0D;
    send(frame_q.size(), 1'b0, 1'b0);
    check_outcome(1'b0);
    do_reload();
    load_fixed();
    send(frame_q.size(), 1'b0, 1'b0);
    check_outcome(1'b1);
    do_reload();

    // Length boundaries.
    frame_q = '{8'h00, 8'h00};
    send(2, 1'b0, 1'b0);
    check_outcome(1'b0);
    do_reload();
    frame_q = '{8'h03, 8'hC1};
    send(2, 1'b0, 1'b0);
    check_outcome(1'b0);
    do_reload();
    build(960, 1'b0);
    send(frame_q.size(), 1'b0, 1'b0);
    check_outcome(1'b1);
    check_eq("last_addr", last_addr, 32'hFFF);
    do_reload();

    // Reset in the middle of the payload, then a clean frame.
    load_fixed();
    send(7, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();
    check_eq("mid_rst_writes", 32'(exp_addr_q.size()), 32'd0);
    send(frame_q.size(), 1'b1, 1'b0);
    check_outcome(1'b1);

    // rst together with reload in DONE, then reload held during a load.
    rst    = 1'b1;
    reload = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    reload = 1'b0;
    check_reset();
    send(frame_q.size(), 1'b0, 1'b1);
    check_outcome(1'b1);
    do_reload();

    // Randomized frames against the model.
    for (int t = 0; t < 10; t++) begin
      build($urandom_range(1, 6), ($urandom_range(0, 2) == 0));
      ok = model_ok();
      send(frame_q.size(), 1'($urandom_range(0, 1)), 1'b0);
      check_outcome(ok);
      do_reload();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
